noc_input_port: RTL and testbench
=================================

Name: noc_input_port

Overview:
- Per-port ingress stage that sits directly upstream of the round-robin crossbar: one instance per crossbar input.
- Buffers incoming flits in a first-word-fall-through FIFO and extracts the destination port from each flit header.
- Presents the head flit to the crossbar as data/dest/dest_en and retires it on a crossbar grant that is not backpressured.
- Generates registered backpressure toward the upstream link.

Parameters:
- PORTS, 2: number of crossbar ports (>=2); destination field width is $clog2(PORTS).
- WIDTH, 8: flit width in bits.
- DEPTH, 4: FIFO entries; power of two, >=2.
- BP_MARGIN, 1: free-slot margin; in_bp asserts when occupancy >= DEPTH-BP_MARGIN; range 0..DEPTH-1.
- DEST_LSB, 0: LSB position of the destination field inside the flit; DEST_LSB+$clog2(PORTS) <= WIDTH.

Ports:
- clk  input  1  clock.
- rst  input  1  asynchronous, active-high reset.
- in_data  input  WIDTH  flit from upstream link.
- in_valid  input  1  in_data valid this cycle.
- in_bp  output  1  registered backpressure to upstream; 1 = stop sending.
- xb_data  output  WIDTH  head flit, to crossbar data_i[n].
- xb_dest  output  $clog2(PORTS)  head flit destination, to crossbar dest[n].
- xb_dest_en  output  1  head flit present, to crossbar dest_en[n].
- xb_ack  input  1  grant from crossbar ack[n]; same-cycle combinational response to xb_dest_en.
- xb_bp  input  1  downstream backpressure returned by crossbar bp_o[n]; only meaningful while xb_ack=1.
- occupancy  output  $clog2(DEPTH)+1  current FIFO entry count.

Behaviour:
- Reset (async, rst=1): rd_ptr=wr_ptr=0, count=0, in_bp=0, occupancy=0, xb_dest_en=0. xb_data and xb_dest are don't-care while xb_dest_en=0. Memory contents are not reset.
- Reset mid-operation discards all buffered flits. The first flit after reset deasserts is accepted normally.
- Storage: DEPTH x WIDTH array with rd_ptr/wr_ptr of $clog2(DEPTH) bits. Pointers wrap naturally modulo DEPTH. count is a separate register of $clog2(DEPTH)+1 bits.
- Head outputs (combinational from registers only, no input-to-output path):
  - xb_dest_en = (count != 0)
  - xb_data = mem[rd_ptr]
  - xb_dest = mem[rd_ptr][DEST_LSB +: $clog2(PORTS)]
- Destination values >= PORTS (non-power-of-two PORTS) are passed through unchanged. Legality is the sender's responsibility.
- pop = xb_dest_en & xb_ack & ~xb_bp. A grant with xb_bp=1 leaves the head in place, and the flit is re-requested next cycle.
- push = in_valid & ((count != DEPTH) | pop). Push is allowed when full if a pop occurs in the same cycle.
- Drop: in_valid while full and no pop discards the flit. This is a protocol violation by the sender; the FIFO state is unchanged.
- Latency: a flit written into an empty FIFO appears on xb_dest_en/xb_data the next cycle. There is no bypass.
- Update rules:
  - push writes mem[wr_ptr] and increments wr_ptr.
  - pop increments rd_ptr.
  - count += push - pop. Simultaneous push and pop leaves count unchanged.
- in_bp is registered: in_bp <= (count_next >= DEPTH-BP_MARGIN).
  - With BP_MARGIN>=1, a sender reacting one cycle late never overflows.
  - With BP_MARGIN=0, in_bp asserts only when full.
- occupancy = count.

Optional Feature:
- Macro: NOC_INPUT_PORT_DROP_CNT_EN.
- When defined:
  - Adds output port drop_cnt (8 bits).
  - drop_cnt resets to 0 and increments by 1 on every dropped flit (in_valid & full & ~pop).
  - drop_cnt saturates at 255.
- When undefined: the port and counter are absent, and drops are silent. All other behaviour is identical in both builds.

Test Plan:
1. Reset, then in_valid=1 with in_data=8'h01 for 1 cycle (PORTS=2, DEST_LSB=0), xb_ack=0 -> next cycle xb_dest_en=1, xb_data=8'h01, xb_dest=1, occupancy=1. Then xb_ack=1, xb_bp=0 for 1 cycle -> following cycle xb_dest_en=0, occupancy=0.
2. Push 8'h10, 8'h21, 8'h32, 8'h43 back-to-back with xb_ack=0 (DEPTH=4, BP_MARGIN=1) -> in_bp=1 the cycle after the 3rd push, occupancy=4. Then ack each cycle -> flits exit in order 10,21,32,43 and in_bp drops to 0 once occupancy<=2.
3. Full FIFO, xb_ack=1 and xb_bp=0, in_valid=1 with 8'h55 in the same cycle -> push accepted, occupancy stays 4, and 8'h55 is the 4th flit out after the current head.
4. Head 8'hA0 held with xb_ack=1, xb_bp=1 for 3 cycles -> xb_data stays A0 and occupancy is unchanged. Then xb_bp=0 -> A0 popped on that cycle.
5. Push 6 flits with wrap (3 pushes, 2 pops, 3 pushes) -> output order matches input order and pointers wrap without loss. With macro defined: 1 push on a full FIFO with no pop -> drop_cnt=1 and contents unchanged.
6. rst pulsed asynchronously mid-cycle with occupancy=3 -> xb_dest_en=0, occupancy=0 and in_bp=0 immediately. The first flit after release appears 1 cycle after its push.

Source files
------------

// File: rtl/noc_input_port.sv
// noc_input_port: per-port ingress stage in front of the round-robin crossbar.
// A first-word-fall-through FIFO buffers flits from the upstream link.
// The head flit is presented to the crossbar together with the destination
// field extracted from that flit. The head is retired on a grant that is not
// backpressured.
// Upstream backpressure (in_bp) is registered and asserts BP_MARGIN slots
// before the FIFO fills.
// Optional feature: define NOC_INPUT_PORT_DROP_CNT_EN to add an 8-bit
// saturating counter (drop_cnt) of flits dropped on a full FIFO.
module noc_input_port #(
  parameter int PORTS     = 2,
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 4,
  parameter int BP_MARGIN = 1,
  parameter int DEST_LSB  = 0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [WIDTH-1:0]           in_data,
  input  logic                       in_valid,
  output logic                       in_bp,
  output logic [WIDTH-1:0]           xb_data,
  output logic [$clog2(PORTS)-1:0]   xb_dest,
  output logic                       xb_dest_en,
  input  logic                       xb_ack,
  input  logic                       xb_bp,
`ifdef NOC_INPUT_PORT_DROP_CNT_EN
  output logic [7:0]                 drop_cnt,
`endif
  output logic [$clog2(DEPTH):0]     occupancy
);

  localparam int DW = $clog2(PORTS);   // destination field width
  localparam int PW = $clog2(DEPTH);   // pointer width
  localparam int CW = PW + 1;          // count width: 0..DEPTH inclusive

  // in_bp asserts once the post-update occupancy reaches this level.
  localparam logic [CW-1:0] BP_THRESH = CW'(DEPTH - BP_MARGIN);
  localparam logic [CW-1:0] FULL_CNT  = CW'(DEPTH);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]    count_q,  count_d;
  logic             in_bp_q,  in_bp_d;

  // Handshake terms
  logic             head_valid;
  logic             full;
  logic             push;
  logic             pop;

  // Memory write port
  logic             mem_wr_en;
  logic [PW-1:0]    mem_wr_addr;
  logic [WIDTH-1:0] mem_wr_data;

  // ---------------------------------------------------------------------------
  // Head presentation: driven from registers only, no input-to-output path.
  // ---------------------------------------------------------------------------
  assign head_valid = (count_q != '0);
  assign full       = (count_q == FULL_CNT);

  assign xb_dest_en = head_valid;
  assign xb_data    = mem_q[rd_ptr_q];
  // Destinations >= PORTS are passed through untouched; legality is the
  // sender's problem, not this stage's.
  assign xb_dest    = xb_data[DEST_LSB +: DW];

  assign occupancy  = count_q;
  assign in_bp      = in_bp_q;

  // ---------------------------------------------------------------------------
  // Handshakes
  // ---------------------------------------------------------------------------
  // A grant with xb_bp=1 is not a retire: the head stays and re-requests.
  assign pop  = head_valid & xb_ack & ~xb_bp;
  // A full FIFO still accepts a flit when the head leaves in the same cycle.
  assign push = in_valid & (~full | pop);

  // Next-state computation for pointers, count and backpressure.
  // NOTE: every signal assigned here gets a default first, so no path through
  // the block can leave it unassigned and infer a latch.
  always_comb begin
    rd_ptr_d    = rd_ptr_q;
    wr_ptr_d    = wr_ptr_q;
    count_d     = count_q;
    mem_wr_en   = 1'b0;
    mem_wr_addr = wr_ptr_q;
    mem_wr_data = in_data;

    if (push) begin
      mem_wr_en = 1'b1;
      // Pointer width equals log2(DEPTH), so wrap is the natural overflow.
      wr_ptr_d  = wr_ptr_q + PW'(1);
    end

    if (pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end

    unique case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;  // idle, or push and pop cancel out
    endcase

    // Registered from next-state count, so in_bp lines up with occupancy.
    in_bp_d = (count_d >= BP_THRESH);
  end

  // Control registers: pointers, count and registered backpressure.
  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge value of every other flop regardless of block order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      in_bp_q  <= 1'b0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      in_bp_q  <= in_bp_d;
    end
  end

  // Flit storage write port.
  // NOTE: the storage array has no reset; count_q=0 already marks every entry
  // invalid, and leaving it unreset lets it map onto plain RAM or
  // non-reset flops.
  always_ff @(posedge clk) begin
    if (mem_wr_en) begin
      mem_q[mem_wr_addr] <= mem_wr_data;
    end
  end

`ifdef NOC_INPUT_PORT_DROP_CNT_EN
  // ---------------------------------------------------------------------------
  // Drop counter: flits offered on a full FIFO with no pop are discarded.
  // ---------------------------------------------------------------------------
  logic       drop;
  logic [7:0] drop_cnt_q, drop_cnt_d;

  assign drop     = in_valid & full & ~pop;
  assign drop_cnt = drop_cnt_q;

  // Saturating increment so a misbehaving sender cannot wrap the count to 0.
  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (drop && (drop_cnt_q != 8'hFF)) begin
      drop_cnt_d = drop_cnt_q + 8'd1;
    end
  end

  // Drop counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      drop_cnt_q <= 8'd0;
    end else begin
      drop_cnt_q <= drop_cnt_d;
    end
  end
`endif

endmodule

// File: tb/tb_noc_input_port.sv
// tb_noc_input_port: scoreboard bench for noc_input_port.
// The reference model is a queue of accepted flits. A monitor samples the DUT
// on the falling edge and compares it against the queue. It then applies the
// cycle's push/pop/drop rules to the queue.
module tb_noc_input_port;

  localparam int PORTS     = 2;
  localparam int WIDTH     = 8;
  localparam int DEPTH     = 4;
  localparam int BP_MARGIN = 1;
  localparam int DEST_LSB  = 0;
  localparam int DW        = $clog2(PORTS);

  logic                     clk;
  logic                     rst;
  logic [WIDTH-1:0]         in_data;
  logic                     in_valid;
  logic                     in_bp;
  logic [WIDTH-1:0]         xb_data;
  logic [DW-1:0]            xb_dest;
  logic                     xb_dest_en;
  logic                     xb_ack;
  logic                     xb_bp;
  logic [$clog2(DEPTH):0]   occupancy;
`ifdef NOC_INPUT_PORT_DROP_CNT_EN
  logic [7:0]               drop_cnt;
`endif

  int checks   = 0;
  int failures = 0;

  noc_input_port #(
    .PORTS(PORTS), .WIDTH(WIDTH), .DEPTH(DEPTH),
    .BP_MARGIN(BP_MARGIN), .DEST_LSB(DEST_LSB)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_bp      (in_bp),
    .xb_data    (xb_data),
    .xb_dest    (xb_dest),
    .xb_dest_en (xb_dest_en),
    .xb_ack     (xb_ack),
    .xb_bp      (xb_bp),
`ifdef NOC_INPUT_PORT_DROP_CNT_EN
    .drop_cnt   (drop_cnt),
`endif
    .occupancy  (occupancy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model and monitor
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] sb_q[$];
  bit               exp_bp   = 1'b0;
  int               exp_drop = 0;

  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        sb_q.delete();
        exp_bp   = 1'b0;
        exp_drop = 0;
        check("rst_dest_en", 32'(xb_dest_en), 32'd0);
        check("rst_occupancy", 32'(occupancy), 32'd0);
        check("rst_in_bp", 32'(in_bp), 32'd0);
      end else begin
        bit do_pop, do_push, is_full;
        int head_dest;
        check("occupancy", 32'(occupancy), 32'(sb_q.size()));
        check("dest_en", 32'(xb_dest_en), 32'(sb_q.size() != 0));
        check("in_bp", 32'(in_bp), 32'(exp_bp));
        if (sb_q.size() != 0) begin
          head_dest = (int'(sb_q[0]) >> DEST_LSB) % (1 << DW);
          check("head_data", 32'(xb_data), 32'(sb_q[0]));
          check("head_dest", 32'(xb_dest), 32'(head_dest));
        end
`ifdef NOC_INPUT_PORT_DROP_CNT_EN
        check("drop_cnt", 32'(drop_cnt), 32'(exp_drop));
`endif
        is_full = (sb_q.size() == DEPTH);
        do_pop  = (sb_q.size() != 0) && xb_ack && !xb_bp;
        do_push = in_valid && (!is_full || do_pop);
        if (in_valid && is_full && !do_pop && exp_drop < 255) exp_drop++;
        if (do_pop) void'(sb_q.pop_front());
        if (do_push) sb_q.push_back(in_data);
        exp_bp = (sb_q.size() >= DEPTH - BP_MARGIN);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  // Apply one cycle of inputs just after a rising edge, hold until the next one.
  task automatic step(input logic v, input logic [7:0] d, input logic a, input logic b);
    in_valid = v;
    in_data  = d;
    xb_ack   = a;
    xb_bp    = b;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst      = 1'b1;
    in_valid = 1'b0;
    in_data  = '0;
    xb_ack   = 1'b0;
    xb_bp    = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Single flit: one-cycle latency, destination bit 1, then retire.
    step(1, 8'h01, 0, 0);
    step(0, 8'h00, 0, 0);
    step(0, 8'h00, 1, 0);
    step(0, 8'h00, 0, 0);

    // Fill to full, watch in_bp, drain in order.
    step(1, 8'h10, 0, 0);
    step(1, 8'h21, 0, 0);
    step(1, 8'h32, 0, 0);
    step(1, 8'h43, 0, 0);
    step(0, 8'h00, 0, 0);
    repeat (5) step(0, 8'h00, 1, 0);

    // Full FIFO with simultaneous push and pop.
    for (int i = 0; i < DEPTH; i++) step(1, 8'(8'h60 + i), 0, 0);
    step(1, 8'h55, 1, 0);
    repeat (6) step(0, 8'h00, 1, 0);

    // Granted but backpressured head stays put.
    step(1, 8'hA0, 0, 0);
    step(0, 8'h00, 0, 0);
    repeat (3) step(0, 8'h00, 1, 1);
    step(0, 8'h00, 1, 0);
    step(0, 8'h00, 0, 0);

    // Pointer wrap: 3 pushes, 2 pops, 3 pushes, drain.
    for (int i = 0; i < 3; i++) step(1, 8'(8'hB0 + i), 0, 0);
    repeat (2) step(0, 8'h00, 1, 0);
    for (int i = 0; i < 3; i++) step(1, 8'(8'hC0 + i), 0, 0);
    repeat (5) step(0, 8'h00, 1, 0);

    // Drop on a full FIFO with no pop; contents must survive.
    for (int i = 0; i < DEPTH; i++) step(1, 8'(8'hD0 + i), 0, 0);
    step(1, 8'hEE, 0, 0);
    step(0, 8'h00, 0, 0);
    repeat (5) step(0, 8'h00, 1, 0);

    // Randomized traffic, including occasional sends that ignore in_bp.
    for (int i = 0; i < 3000; i++) begin
      logic v;
      v = ($urandom_range(0, 3) != 0) && (!in_bp || $urandom_range(0, 7) == 0);
      step(v, 8'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) == 0));
    end
    repeat (6) step(0, 8'h00, 1, 0);

    // Asynchronous reset mid-cycle with three flits buffered.
    for (int i = 0; i < 3; i++) step(1, 8'(8'hF0 + i), 0, 0);
    in_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("async_rst_dest_en", 32'(xb_dest_en), 32'd0);
    check("async_rst_occupancy", 32'(occupancy), 32'd0);
    check("async_rst_in_bp", 32'(in_bp), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    step(1, 8'h01, 0, 0);
    step(0, 8'h00, 0, 0);
    step(0, 8'h00, 1, 0);
    step(0, 8'h00, 0, 0);

    @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
